// File: rtl/thor_pkg.sv
// Shared definitions for the thor front end: instruction width, the NOP
// used to fill empty decode slots, and the two-instruction fetch packet.
package thor_pkg;

  localparam int INS_W = 32;

  // addi x0, x0, 0
  localparam logic [INS_W-1:0] NOP_INSN = 32'h0000_0013;

  // One fetch packet; insA is the older instruction.
  typedef struct packed {
    logic [INS_W-1:0] insA;
    logic [INS_W-1:0] insB;
  } fetch_pkt_t;

endpackage : thor_pkg

// File: rtl/ins_buffer_mem.sv
// Packet storage for ins_buffer: DEPTH entries of one fetch packet each,
// one synchronous write port and one asynchronous (show-ahead) read port.
module ins_buffer_mem
  import thor_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  fetch_pkt_t    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output fetch_pkt_t    o_rdata
);

  fetch_pkt_t r_mem [DEPTH];

  // Write the accepted packet at the tail slot.
  // NOTE: storage has no reset; head/tail/count gate every read, so stale
  // contents are never observed and the array can map to plain RAM/flops.
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Head entry is read combinationally so ID sees it in the same cycle.
  assign o_rdata = r_mem[i_raddr];

endmodule : ins_buffer_mem

// File: rtl/ins_buffer.sv
// Instruction buffer between fetch and ID_STAGE: circular FIFO of
// two-instruction fetch packets with show-ahead head and single-cycle flush.
// Optional feature: define INSBUF_BYPASS_EN to let a packet pushed into an
// empty buffer reach insA/insB in the same cycle.
module ins_buffer
  import thor_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             flush,
  input  logic             pushValid,
  input  logic [INS_W-1:0] pushInsA,
  input  logic [INS_W-1:0] pushInsB,
  output logic             full,
  output logic             queueEmpty,
  input  logic             pop,
  output logic [INS_W-1:0] insA,
  output logic [INS_W-1:0] insB
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic       w_stored_empty;
  logic       w_bypass;
  logic       w_push_acc;
  logic       w_pop_acc;
  fetch_pkt_t w_push_pkt;
  fetch_pkt_t w_head_pkt;

  assign w_stored_empty = (r_count == '0);

  // full depends only on the count register, so a pop at full cannot open
  // a slot for a push in the same cycle and pop has no path to full.
  assign full = (r_count == FULL_CNT);

`ifdef INSBUF_BYPASS_EN
  // Flush cancels the bypass so a redirect never leaks a stale packet to ID.
  assign w_bypass = w_stored_empty && pushValid && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed packet that ID pops in the same cycle is never stored.
  assign w_push_acc = pushValid && !full && !(w_bypass && pop);
  assign w_pop_acc  = pop && !w_stored_empty;

  assign w_push_pkt = '{insA: pushInsA, insB: pushInsB};

  ins_buffer_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock   (clock),
    .i_we    (w_push_acc && !flush),
    .i_waddr (r_tail),
    .i_wdata (w_push_pkt),
    .i_raddr (r_head),
    .o_rdata (w_head_pkt)
  );

  // Pointer and occupancy update; flush outranks push and pop.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_acc) r_tail <= r_tail + AW'(1);
      if (w_pop_acc)  r_head <= r_head + AW'(1);
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Show-ahead outputs: head entry, bypassed push data, or NOP when empty.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    queueEmpty = w_stored_empty;
    insA       = NOP_INSN;
    insB       = NOP_INSN;
    if (!w_stored_empty) begin
      insA = w_head_pkt.insA;
      insB = w_head_pkt.insB;
    end
`ifdef INSBUF_BYPASS_EN
    else if (w_bypass) begin
      queueEmpty = 1'b0;
      insA       = pushInsA;
      insB       = pushInsB;
    end
`endif
  end

endmodule : ins_buffer

// File: tb/tb_ins_buffer.sv
// Directed, table-driven bench for ins_buffer (DEPTH = 4). Each vector holds
// the inputs for one cycle and the outputs expected while they are applied.
module tb_ins_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef INSBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn;
  logic        flush;
  logic        pushValid;
  logic [31:0] pushInsA;
  logic [31:0] pushInsB;
  logic        full;
  logic        queueEmpty;
  logic        pop;
  logic [31:0] insA;
  logic [31:0] insB;

  ins_buffer #(.DEPTH(4)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .flush      (flush),
    .pushValid  (pushValid),
    .pushInsA   (pushInsA),
    .pushInsB   (pushInsB),
    .full       (full),
    .queueEmpty (queueEmpty),
    .pop        (pop),
    .insA       (insA),
    .insB       (insB)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        fl;
    logic        pv;
    logic [31:0] pa;
    logic [31:0] pb;
    logic        pp;
    logic        e_empty;
    logic        e_full;
    logic [31:0] e_a;
    logic [31:0] e_b;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic fl, input logic pv, input logic [31:0] pa,
                              input logic pp, input logic ee, input logic ef,
                              input logic [31:0] ea);
    vec_t v;
    v.fl = fl; v.pv = pv; v.pa = pa; v.pb = pa + 32'h100; v.pp = pp;
    v.e_empty = ee; v.e_full = ef;
    v.e_a = ea;
    v.e_b = (ea == NOP) ? NOP : ea + 32'h100;
    return v;
  endfunction

  // Idle cycle observing the given head (NOP means empty).
  function automatic vec_t idle(input logic [31:0] head, input logic f);
    return mk(0, 0, 0, 0, head == NOP, f, head);
  endfunction

  // Push into a buffer whose stored count is zero: visible only with bypass.
  function automatic vec_t push_empty(input logic [31:0] a, input logic pp);
    return mk(0, 1, a, pp, !BYP, 0, BYP ? a : NOP);
  endfunction

  task automatic drive(input vec_t v);
    flush = v.fl; pushValid = v.pv; pushInsA = v.pa; pushInsB = v.pb; pop = v.pp;
  endtask

  initial begin
    // Fill/drain: 4 pushes, dropped 5th, 4 pops in order.
    vecs.push_back(idle(NOP, 0));
    vecs.push_back(push_empty(32'h100, 0));
    for (int i = 1; i < 4; i++) vecs.push_back(mk(0, 1, 32'h100 + i, 0, 0, 0, 32'h100));
    vecs.push_back(mk(0, 1, 32'h104, 0, 0, 1, 32'h100));           // dropped at full
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 1, 0, i == 0, 32'h100 + i));
    vecs.push_back(idle(NOP, 0));
    // Streaming at occupancy 2 for 10 cycles; pointers wrap.
    vecs.push_back(push_empty(32'h300, 0));
    vecs.push_back(mk(0, 1, 32'h301, 0, 0, 0, 32'h300));
    for (int k = 0; k < 10; k++) vecs.push_back(mk(0, 1, 32'h302 + k, 1, 0, 0, 32'h300 + k));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'h30A));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'h30B));
    vecs.push_back(idle(NOP, 0));
    // Push+pop at full: pop wins, push dropped, next push accepted.
    vecs.push_back(push_empty(32'h500, 0));
    for (int i = 1; i < 4; i++) vecs.push_back(mk(0, 1, 32'h500 + i, 0, 0, 0, 32'h500));
    vecs.push_back(mk(0, 1, 32'h504, 1, 0, 1, 32'h500));
    vecs.push_back(mk(0, 1, 32'h505, 0, 0, 0, 32'h501));
    vecs.push_back(idle(32'h501, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 32'h501));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'h502));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'h503));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'h505));
    vecs.push_back(idle(NOP, 0));
    // Flush with push and pop at occupancy 3, then a push right after.
    vecs.push_back(push_empty(32'h600, 0));
    vecs.push_back(mk(0, 1, 32'h601, 0, 0, 0, 32'h600));
    vecs.push_back(mk(0, 1, 32'h602, 0, 0, 0, 32'h600));
    vecs.push_back(mk(1, 1, 32'h603, 1, 0, 0, 32'h600));
    vecs.push_back(push_empty(32'h610, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'h610));
    vecs.push_back(idle(NOP, 0));
    // Flush on an empty buffer with a push: flush suppresses the bypass.
    vecs.push_back(mk(1, 1, 32'h620, 0, 1, 0, NOP));
    vecs.push_back(idle(NOP, 0));
    // Push with pop into an empty buffer.
    vecs.push_back(push_empty(32'hAAAA0001, 1));
    vecs.push_back(mk(0, 0, 0, 1, BYP, 0, BYP ? NOP : 32'hAAAA0001));
    vecs.push_back(idle(NOP, 0));
  end

  initial begin
    vec_t v;
    resetn = 1'b0;
    v = idle(NOP, 0);
    drive(v);
    #1;
    check("reset queueEmpty", {31'b0, queueEmpty}, 32'd1);
    check("reset full", {31'b0, full}, 32'd0);
    check("reset insA", insA, NOP);
    check("reset insB", insB, NOP);
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clock);
      #1;
      drive(vecs[i]);
      @(negedge clock);
      check($sformatf("v%0d queueEmpty", i), {31'b0, queueEmpty}, {31'b0, vecs[i].e_empty});
      check($sformatf("v%0d full", i), {31'b0, full}, {31'b0, vecs[i].e_full});
      check($sformatf("v%0d insA", i), insA, vecs[i].e_a);
      check($sformatf("v%0d insB", i), insB, vecs[i].e_b);
    end

    // Asynchronous reset mid-operation: fill to 4, then reset between edges.
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      drive(mk(0, 1, 32'h700 + i, 0, 0, 0, NOP));
    end
    @(posedge clock);
    #1;
    drive(idle(NOP, 0));
    @(negedge clock);
    check("pre-reset full", {31'b0, full}, 32'd1);
    check("pre-reset insA", insA, 32'h700);
    #2;
    resetn = 1'b0;
    #1;
    check("async reset queueEmpty", {31'b0, queueEmpty}, 32'd1);
    check("async reset full", {31'b0, full}, 32'd0);
    check("async reset insA", insA, NOP);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    check("post-reset queueEmpty", {31'b0, queueEmpty}, 32'd1);
    check("post-reset insB", insB, NOP);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_ins_buffer
